z80_bus_target: RTL and testbench

// - Z80 memory-bus responder: decodes CPU memory cycles to a register window and runs
//   an internal req/ack transfer for each hit, stretching the CPU cycle with nWAIT.
// - Sits between the Z80 core's bus (SDA/SDD/strobes, same CLK) and the 054539

---
 rtl/z80_bus_target.sv | 122 ++++++++++++
 tb/tb_z80_bus_target.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/z80_bus_target.sv
// Z80 memory-bus responder: decodes a register window, runs one req/ack transfer per CPU
// cycle and stretches the cycle with nWAIT. Define Z80TGT_TIMEOUT_EN to build the BUSY timeout.
module z80_bus_target #(
  parameter logic [15:0] BASE_ADDR      = 16'hE000,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [15:0]          SDA,
  input  logic [7:0]           SDD_IN,
  input  logic                 nMREQ,
  input  logic                 nRD,
  input  logic                 nWR,
  output logic                 nWAIT,
  output logic [7:0]           Z_DOUT,
  output logic                 DOE,
  output logic [ADDR_BITS-1:0] REG_ADDR,
  output logic [7:0]           REG_WDATA,
  output logic                 REG_WE,
  output logic                 REG_RE,
  input  logic [7:0]           REG_RDATA,
  input  logic                 REG_ACK,
  output logic                 TIMEOUT_FLAG
);

  // state | meaning
  // IDLE  | waiting for a CPU strobe inside the window
  // BUSY  | request pulsed, waiting for REG_ACK (or timeout), CPU held in WAIT
  // DONE  | transfer finished, drive read data until the CPU cycle ends
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic   hit;
  logic   is_read;
  logic   tmo;

  assign hit = ~nMREQ & (SDA[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]) & (~nRD | ~nWR);

`ifdef Z80TGT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_flag_q;

  // Down-counter reloads while idle; terminal count on the last allowed BUSY cycle.
  assign tmo = (state == BUSY) && (tmo_cnt == '0) && !REG_ACK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmo_cnt    <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state == IDLE)
        tmo_cnt <= CW'(TIMEOUT_CYCLES - 1);
      else if ((state == BUSY) && (tmo_cnt != '0))
        tmo_cnt <= tmo_cnt - 1'b1;
      if (tmo)
        tmo_flag_q <= 1'b1;
    end
  end

  assign TIMEOUT_FLAG = tmo_flag_q;
`else
  assign tmo          = 1'b0;
  assign TIMEOUT_FLAG = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // nWAIT is forced high during RESET so the CPU is released even with strobes still low.
  always_comb begin
    state_nxt = state;
    nWAIT     = 1'b1;
    DOE       = 1'b0;
    case (state)
      IDLE: begin
        if (hit && !RESET) begin
          nWAIT     = 1'b0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        nWAIT = 1'b0;
        if (REG_ACK || tmo) state_nxt = DONE;
      end
      DONE: begin
        DOE = is_read & ~nRD;
        if (nMREQ && nRD && nWR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_RE    <= 1'b0;
      REG_WE    <= 1'b0;
      is_read   <= 1'b0;
      Z_DOUT    <= '0;
    end else begin
      REG_RE <= 1'b0;
      REG_WE <= 1'b0;
      if ((state == IDLE) && hit) begin
        REG_ADDR  <= SDA[ADDR_BITS-1:0];
        REG_WDATA <= SDD_IN;
        is_read   <= ~nRD;
        REG_RE    <= ~nRD;
        REG_WE    <= nRD;
      end
      if ((state == BUSY) && is_read) begin
        if (REG_ACK)  Z_DOUT <= REG_RDATA;
        else if (tmo) Z_DOUT <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_target.sv
// Bench for z80_bus_target: a CPU/peripheral driver with a transaction-level reference model.
// Compile with +define+Z80TGT_TIMEOUT_EN to also exercise the timeout build.
module tb_z80_bus_target;
  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] SDA = '0;
  logic [7:0]  SDD_IN = '0;
  logic        nMREQ = 1'b1, nRD = 1'b1, nWR = 1'b1;
  logic        nWAIT, DOE, REG_WE, REG_RE, TIMEOUT_FLAG;
  logic [7:0]  Z_DOUT, REG_WDATA;
  logic [7:0]  REG_RDATA = '0;
  logic        REG_ACK = 1'b0;
  logic [9:0]  REG_ADDR;

  int total = 0, bad = 0;

  // reference model state, one entry per CPU cycle outcome
  logic [9:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_zdout = '0;
  bit         m_flag = 0, m_blocked = 0, m_last_rd = 0;

  always #5 CLK = ~CLK;

  z80_bus_target #(.BASE_ADDR(16'hE000), .ADDR_BITS(10), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .SDA(SDA), .SDD_IN(SDD_IN), .nMREQ(nMREQ), .nRD(nRD),
    .nWR(nWR), .nWAIT(nWAIT), .Z_DOUT(Z_DOUT), .DOE(DOE), .REG_ADDR(REG_ADDR),
    .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_RDATA(REG_RDATA),
    .REG_ACK(REG_ACK), .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One Z80 memory cycle; the peripheral acks dly cycles after seeing the request pulse.
  task automatic cpu_access(input logic [15:0] a, input logic [7:0] wd, input bit rd,
                            input int dly, input logic [7:0] rdat, input bit keep_mreq);
    bit hit, go, done, timed_out, doe_end;
    int waits, n_re, n_we, pc, cyc, exp_waits;
    logic [7:0] zd_end;
    hit = (a >= 16'hE000) && (a <= 16'hE3FF);
    go = hit && !m_blocked;
    done = 0; waits = 0; n_re = 0; n_we = 0; pc = -1; cyc = 0;
    doe_end = 0; zd_end = '0;
    while (!done && cyc < 60) begin
      @(negedge CLK);
      SDA = a; SDD_IN = wd; nMREQ = 1'b0;
      nRD = !rd;
      nWR = !(!rd && cyc >= 1);
      REG_ACK = (pc >= 0) && (cyc == pc + dly);
      REG_RDATA = REG_ACK ? rdat : 8'($urandom);
      #1;
      if (REG_RE) begin n_re++; if (pc < 0) pc = cyc; end
      if (REG_WE) begin n_we++; if (pc < 0) pc = cyc; end
      if (!nWAIT) waits++;
      else if (!nRD || !nWR) begin
        done = 1; doe_end = DOE; zd_end = Z_DOUT;
      end
      cyc++;
    end
    chk("cycle_ends", 32'(done), 32'd1);
    REG_ACK = 1'b0;

    timed_out = 0;
    exp_waits = go ? dly + 2 : 0;
`ifdef Z80TGT_TIMEOUT_EN
    if (go && dly + 1 > TMO) begin
      timed_out = 1;
      exp_waits = TMO + 1;
    end
`endif
    chk("wait_cycles", 32'(waits), 32'(exp_waits));
    chk("re_pulses", 32'(n_re), 32'(go && rd));
    chk("we_pulses", 32'(n_we), 32'(go && !rd));
    chk("doe_strobe", 32'(doe_end), 32'(go ? rd : (m_blocked && m_last_rd && rd)));
    if (go) begin
      m_addr = a[9:0];
      m_wdata = wd;
      m_last_rd = rd;
      if (rd) m_zdout = timed_out ? 8'hFF : rdat;
      if (timed_out) m_flag = 1;
    end
    chk("z_dout", 32'(zd_end), 32'(m_zdout));
    chk("reg_addr", 32'(REG_ADDR), 32'(m_addr));
    chk("reg_wdata", 32'(REG_WDATA), 32'(m_wdata));
    chk("timeout_flag", 32'(TIMEOUT_FLAG), 32'(m_flag));

    @(negedge CLK);
    nRD = 1'b1; nWR = 1'b1;
    if (!keep_mreq) nMREQ = 1'b1;
    #1;
    chk("doe_release", 32'(DOE), 32'd0);
    chk("nwait_release", 32'(nWAIT), 32'd1);
    m_blocked = keep_mreq && go;
  endtask

  initial begin
    int n_pulse;
    logic [15:0] a;
    bit keep;

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_nwait", 32'(nWAIT), 32'd1);
    chk("rst_doe", 32'(DOE), 32'd0);
    chk("rst_zdout", 32'(Z_DOUT), 32'd0);
    chk("rst_addr", 32'(REG_ADDR), 32'd0);
    chk("rst_wdata", 32'(REG_WDATA), 32'd0);
    chk("rst_pulses", 32'({REG_RE, REG_WE}), 32'd0);
    chk("rst_flag", 32'(TIMEOUT_FLAG), 32'd0);
    RESET = 1'b0;

    cpu_access(16'hE005, 8'h00, 1, 2, 8'h5A, 0);
    cpu_access(16'hE3FF, 8'hC3, 0, 1, 8'h00, 0);
    cpu_access(16'hDFFF, 8'h11, 1, 1, 8'h77, 0);
    cpu_access(16'hE400, 8'h22, 1, 1, 8'h78, 0);
    cpu_access(16'hE001, 8'h00, 1, 1, 8'h11, 0);
    cpu_access(16'hE002, 8'h00, 1, 3, 8'h22, 0);
    cpu_access(16'hE0AA, 8'h00, 1, 2, 8'h33, 1);
    cpu_access(16'hE0AB, 8'h00, 1, 2, 8'h44, 0);
    cpu_access(16'hE0AC, 8'h00, 1, 1, 8'h55, 0);

    // reset in the middle of a read transfer
    @(negedge CLK); SDA = 16'hE020; nMREQ = 1'b0; nRD = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_nwait", 32'(nWAIT), 32'd1);
    chk("midrst_doe", 32'(DOE), 32'd0);
    chk("midrst_re", 32'(REG_RE), 32'd0);
    @(negedge CLK); nMREQ = 1'b1; nRD = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    m_addr = '0; m_wdata = '0; m_zdout = '0; m_flag = 0; m_blocked = 0; m_last_rd = 0;
    n_pulse = 0;
    repeat (4) begin
      @(negedge CLK); #1;
      if (REG_RE || REG_WE) n_pulse++;
    end
    chk("midrst_no_pulse", 32'(n_pulse), 32'd0);
    chk("midrst_addr", 32'(REG_ADDR), 32'd0);
    cpu_access(16'hE010, 8'h00, 1, 2, 8'hA5, 0);

`ifdef Z80TGT_TIMEOUT_EN
    cpu_access(16'hE030, 8'h00, 1, 1000, 8'h00, 0);
    cpu_access(16'hE031, 8'h66, 0, 2, 8'h00, 0);
    cpu_access(16'hE032, 8'h00, 1, 1, 8'h9C, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'hE000 | 16'($urandom_range(0, 1023));
        1: a = 16'($urandom);
        2: a = $urandom_range(0, 1) ? 16'hE000 : 16'hE3FF;
        default: a = $urandom_range(0, 1) ? 16'hDFFF : 16'hE400;
      endcase
      keep = !m_blocked && ($urandom_range(0, 3) == 0);
      cpu_access(a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 5),
                 8'($urandom), keep);
    end
    cpu_access(16'hE100, 8'h00, 1, 1, 8'h3C, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
